commit_stage: RTL and testbench
===============================

Name: commit_stage

Overview:
- Terminal stage of the main branch; sits directly downstream of the saturate stage.
- Accepts finished results tagged with a commit id, which may arrive out of order relative to results from other branches.
- Holds them in a small reorder window.
- Retires them strictly in commit-id order as register-file or accumulator writes, one per cycle.

Parameters:
- data_width, 16, width of a register-file word; accumulator/result width is 2*data_width.
- window_log2, 3, log2 of reorder window depth (8 slots).
- id_width, 9, commit id width; ids wrap modulo 2^id_width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global stall; when low, no state changes and no write pulses
- flush  in  1  synchronous clear of window; next_id loaded from flush_id
- flush_id  in  id_width  first id expected after flush
- in_valid  in  1  result offered
- in_ready  out  1  result can be accepted this cycle
- result_in  in  2*data_width  signed result (already saturated if requested)
- dest_in  in  4  destination register index
- dest_acc_in  in  1  1 = write accumulator, 0 = write register file
- commit_id_in  in  id_width  commit id of result
- reg_we  out  1  register-file write strobe (1-cycle pulse)
- reg_waddr  out  4  register-file write address
- reg_wdata  out  data_width  result_in[data_width-1:0] of retired entry
- acc_we  out  1  accumulator write strobe (1-cycle pulse)
- acc_wdata  out  2*data_width  full retired result
- retired_id  out  id_width  id of entry retired in the cycle a strobe is high
- next_id  out  id_width  id the stage is waiting to retire
- window_empty  out  1  no slot occupied

Behaviour:
- Reset values:
  - Asynchronous: all slot-valid bits 0; next_id 0.
  - reg_we 0, acc_we 0, reg_waddr 0, reg_wdata 0, acc_wdata 0, retired_id 0.
  - window_empty 1.
- Storage: 2^window_log2 slots indexed by commit_id[window_log2-1:0]. Each slot holds valid, result, dest, dest_acc.
- Window check: offset = (commit_id_in - next_id) mod 2^id_width. The id is in window iff offset < 2^window_log2.
- in_ready = enable & ~flush & in_window & ~slot_valid[index]. It is combinational from commit_id_in and state; this is a documented exception to the registered-ready rule of other stages.
- Accept: on in_valid & in_ready, the slot is written and marked valid at the clock edge.
- Retire:
  - Each enabled cycle, if slot[next_id index] is valid, that entry is retired at the edge.
  - The slot is cleared and next_id increments (wraps 511->0).
  - Exactly one of reg_we/acc_we is registered high for one cycle, per dest_acc, with data/address/retired_id registered alongside.
  - Strobes are 0 in any cycle with no retirement.
- Latency: a result accepted at edge N, with its id equal to next_id, appears on the write ports after edge N+1. There is no same-cycle bypass.
- Simultaneous accept and retire: permitted in the same cycle to different slots. The same slot cannot be hit: the head slot, if valid, blocks any id aliasing onto it, and aliasing ids are out of window anyway.
- Gaps: if the head slot is empty, nothing retires. Later slots stay held indefinitely until the missing id arrives.
- enable low: all state frozen; strobes forced 0 next edge; in_ready 0.
- flush (synchronous, priority over accept and retire):
  - All valid bits cleared, next_id <= flush_id.
  - Strobes 0 next edge; any in-flight offer is dropped.
- Reset mid-operation: buffered entries are discarded; no write strobe is emitted from the reset edge onward.
- Duplicate id while the slot is occupied: in_ready stays 0, so the offer stalls. Upstream must not deadlock, because the occupant retires once earlier ids arrive.

Decomposition:
- Shared package/header (alongside block.vh): commit id width, default window_log2, and dest field encodings (dest width 4, dest_acc semantics).
- One natural sub-module, commit_window_slot_ram: slot storage with a write port plus a read port at the head index. It keeps valid bits in flops so they can be cleared in a single cycle on flush.

Test Plan:
- In-order stream: ids 0,1,2 with results 0x00000005, 0xFFFFFFFE, 0x12345678, dest 3,4,5, dest_acc 0,0,1 -> reg writes (3,0x0005), (4,0xFFFE), then acc_we with 0x12345678, on consecutive cycles one cycle after each accept; next_id=3.
- Out-of-order: offer ids 2, 1, 0 -> no strobe until id 0 accepted, then retires 0,1,2 on three consecutive cycles, in order.
- Window full / out of window: next_id=0, offer id 8 -> in_ready=0. Accept id 0, after retirement offer id 8 again -> accepted.
- Wrap-around: flush with flush_id=510; offer ids 510, 511, 0, 1 -> retired_id sequence 510, 511, 0, 1; next_id=2.
- enable deasserted for 3 cycles with ids 0,1 buffered -> no strobes during stall; retirement resumes in order after enable returns.
- Async reset asserted mid-cycle with 3 slots valid -> outputs immediately 0, window_empty=1, next_id=0. No strobe after release until a new id 0 is accepted.

Source files
------------

// File: rtl/commit_stage_pkg.sv
// commit_stage_pkg: shared widths, window depth default and destination encodings for the commit stage
package commit_stage_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int WINDOW_LOG2 = 3;
  localparam int ID_WIDTH = 9;
  localparam int DEST_WIDTH = 4;
  typedef enum logic {DEST_REG = 1'b0, DEST_ACC = 1'b1} dest_sel_e;
endpackage

// File: rtl/commit_window_slot_ram.sv
// commit_window_slot_ram: reorder slots (we/waddr/wdata write, clr/raddr head read+clear, flush clears all valid bits, valid_o per-slot flags)
module commit_window_slot_ram #(
  parameter int W = 37,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [W-1:0]      rdata_o,
  output logic [2**AW-1:0]  valid_o
);
  localparam int N = 2**AW;
  logic [W-1:0] mem_q [N];
  logic [N-1:0] valid_q, valid_d;
  always_comb begin
    valid_d = valid_q;
    if (clr_i) valid_d[raddr_i] = 1'b0;
    if (we_i) valid_d[waddr_i] = 1'b1;
    if (flush_i) valid_d = '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
  assign valid_o = valid_q;
endmodule

// File: rtl/commit_stage.sv
// commit_stage: reorder window retiring results in commit-id order as one reg-file (reg_we/waddr/wdata) or accumulator (acc_we/wdata) write per cycle
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int window_log2 = WINDOW_LOG2,
  parameter int id_width = ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [id_width-1:0]     flush_id,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*data_width-1:0] result_in,
  input  logic [DEST_WIDTH-1:0]   dest_in,
  input  logic                    dest_acc_in,
  input  logic [id_width-1:0]     commit_id_in,
  output logic                    reg_we,
  output logic [DEST_WIDTH-1:0]   reg_waddr,
  output logic [data_width-1:0]   reg_wdata,
  output logic                    acc_we,
  output logic [2*data_width-1:0] acc_wdata,
  output logic [id_width-1:0]     retired_id,
  output logic [id_width-1:0]     next_id,
  output logic                    window_empty
);
  localparam int RW = 2*data_width;
  localparam int SW = RW + DEST_WIDTH + 1;
  logic [id_width-1:0] next_id_q, next_id_d, offset, retired_id_q, retired_id_d;
  logic [2**window_log2-1:0] slot_valid;
  logic [SW-1:0] head_word;
  logic [RW-1:0] head_result, result_q, result_d;
  logic [DEST_WIDTH-1:0] head_dest, waddr_q, waddr_d;
  logic head_acc, in_window, accept, retire, flush_go, reg_we_q, reg_we_d, acc_we_q, acc_we_d;
  assign offset = commit_id_in - next_id_q;
  assign in_window = offset[id_width-1:window_log2] == '0;
  assign in_ready = enable & ~flush & in_window & ~slot_valid[commit_id_in[window_log2-1:0]];
  assign accept = in_valid & in_ready;
  assign flush_go = enable & flush;
  assign retire = enable & ~flush & slot_valid[next_id_q[window_log2-1:0]];
  assign {head_result, head_dest, head_acc} = head_word;
  commit_window_slot_ram #(.W(SW), .AW(window_log2)) u_slots (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_go),
    .we_i    (accept),
    .waddr_i (commit_id_in[window_log2-1:0]),
    .wdata_i ({result_in, dest_in, dest_acc_in}),
    .clr_i   (retire),
    .raddr_i (next_id_q[window_log2-1:0]),
    .rdata_o (head_word),
    .valid_o (slot_valid)
  );
  always_comb begin
    next_id_d = flush_go ? flush_id : retire ? next_id_q + 1'b1 : next_id_q;
    reg_we_d = retire & (head_acc == DEST_REG);
    acc_we_d = retire & (head_acc == DEST_ACC);
    result_d = retire ? head_result : result_q;
    waddr_d = retire ? head_dest : waddr_q;
    retired_id_d = retire ? next_id_q : retired_id_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_id_q <= '0;
      reg_we_q <= 1'b0;
      acc_we_q <= 1'b0;
      result_q <= '0;
      waddr_q <= '0;
      retired_id_q <= '0;
    end else begin
      next_id_q <= next_id_d;
      reg_we_q <= reg_we_d;
      acc_we_q <= acc_we_d;
      result_q <= result_d;
      waddr_q <= waddr_d;
      retired_id_q <= retired_id_d;
    end
  end
  assign reg_we = reg_we_q;
  assign acc_we = acc_we_q;
  assign reg_waddr = waddr_q;
  assign reg_wdata = result_q[data_width-1:0];
  assign acc_wdata = result_q;
  assign retired_id = retired_id_q;
  assign next_id = next_id_q;
  assign window_empty = ~|slot_valid;
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: randomized and directed checks of commit_stage against an id-keyed reorder model
module tb_commit_stage;
  logic clk = 1'b0;
  logic reset, enable, flush, in_valid, in_ready, dest_acc_in;
  logic [8:0] flush_id, commit_id_in, retired_id, next_id;
  logic [31:0] result_in, acc_wdata;
  logic [3:0] dest_in, reg_waddr;
  logic [15:0] reg_wdata;
  logic reg_we, acc_we, window_empty;

  commit_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .flush_id(flush_id),
    .in_valid(in_valid), .in_ready(in_ready), .result_in(result_in), .dest_in(dest_in),
    .dest_acc_in(dest_acc_in), .commit_id_in(commit_id_in), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .acc_we(acc_we), .acc_wdata(acc_wdata),
    .retired_id(retired_id), .next_id(next_id), .window_empty(window_empty)
  );

  always #5 clk = ~clk;

  bit m_present [512];
  logic [31:0] m_res [512];
  logic [3:0] m_dest [512];
  bit m_acc [512];
  int m_next, m_cnt;
  logic [73:0] obs_all, exp_all;
  int n_vec = 0, n_bad = 0;

  function automatic bit model_ready();
    int off;
    off = (int'(commit_id_in) - m_next + 512) % 512;
    return enable && !flush && off < 8 && !m_present[commit_id_in];
  endfunction

  task automatic model_reset();
    foreach (m_present[i]) m_present[i] = 1'b0;
    m_next = 0;
    m_cnt = 0;
  endtask

  task automatic drv(input bit v, input int id, input logic [31:0] r, input logic [3:0] d,
                     input bit a, input bit en, input bit fl, input int fid);
    in_valid = v;
    commit_id_in = 9'(id);
    result_in = r;
    dest_in = d;
    dest_acc_in = a;
    enable = en;
    flush = fl;
    flush_id = 9'(fid);
  endtask

  task automatic tick();
    bit er, rdy;
    logic [62:0] ew;
    int id;
    #1;
    er = model_ready();
    rdy = in_ready;
    @(posedge clk);
    ew = '0;
    if (enable) begin
      if (flush) begin
        model_reset();
        m_next = int'(flush_id);
      end else begin
        if (m_present[m_next]) begin
          id = m_next;
          ew = {!m_acc[id], m_acc[id], 9'(id), m_acc[id] ? 4'd0 : m_dest[id],
                m_acc[id] ? 16'd0 : m_res[id][15:0], m_acc[id] ? m_res[id] : 32'd0};
          m_present[id] = 1'b0;
          m_cnt--;
          m_next = (m_next + 1) % 512;
        end
        if (in_valid && er) begin
          id = int'(commit_id_in);
          m_present[id] = 1'b1;
          m_res[id] = result_in;
          m_dest[id] = dest_in;
          m_acc[id] = dest_acc_in;
          m_cnt++;
        end
      end
    end
    #1;
    obs_all = {rdy, reg_we, acc_we, (reg_we | acc_we) ? retired_id : 9'd0, reg_we ? reg_waddr : 4'd0,
               reg_we ? reg_wdata : 16'd0, acc_we ? acc_wdata : 32'd0, next_id, window_empty};
    exp_all = {er, ew, 9'(m_next), m_cnt == 0};
    @(negedge clk);
  endtask

  task automatic test_reset();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({reg_we, acc_we, reg_waddr, reg_wdata, acc_wdata, retired_id, next_id, window_empty} !== {67'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_values got %b %b %h %h %h %h %h %b", reg_we, acc_we, reg_waddr, reg_wdata, acc_wdata, retired_id, next_id, window_empty);
    end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL reset_idle c%0d got %h exp %h", c, obs_all, exp_all); end
    end
  endtask

  task automatic test_in_order();
    logic [31:0] res [3] = '{32'h00000005, 32'hFFFFFFFE, 32'h12345678};
    logic [35:0] want [3] = '{{1'b1, 1'b0, 4'd3, 16'h0005, 14'd0}, {1'b1, 1'b0, 4'd4, 16'hFFFE, 14'd0}, {1'b0, 1'b1, 4'd0, 16'd0, 14'd0}};
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drv(1, c, res[c], 4'(c + 3), c == 2, 1, 0, 0);
      else drv(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL in_order c%0d got %h exp %h", c, obs_all, exp_all); end
      if (c >= 1 && c <= 3) begin
        n_vec++;
        if ({reg_we, acc_we, reg_we ? reg_waddr : 4'd0, reg_we ? reg_wdata : 16'd0, 14'd0} !== want[c-1] ||
            (acc_we && acc_wdata !== 32'h12345678) || retired_id !== 9'(c - 1)) begin
          n_bad++;
          $display("FAIL in_order_write c%0d got we%b/%b a%h d%h acc%h id%0d", c, reg_we, acc_we, reg_waddr, reg_wdata, acc_wdata, retired_id);
        end
      end
    end
    n_vec++;
    if (next_id !== 9'd3) begin n_bad++; $display("FAIL in_order_next_id got %0d exp 3", next_id); end
  endtask

  task automatic test_out_of_order();
    drv(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drv(1, 2 - c, $urandom, 4'(c), 0, 1, 0, 0);
      else drv(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL out_of_order c%0d got %h exp %h", c, obs_all, exp_all); end
      n_vec++;
      if ((c >= 3 && c <= 5) ? (!reg_we || retired_id !== 9'(c - 3)) : (reg_we || acc_we)) begin
        n_bad++;
        $display("FAIL out_of_order_seq c%0d got we%b id%0d", c, reg_we, retired_id);
      end
    end
  endtask

  task automatic test_window();
    drv(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drv(1, 8, 32'hAAAA5555, 1, 0, 1, 0, 0);
    tick();
    n_vec++;
    if (obs_all[73] !== 1'b0 || obs_all !== exp_all) begin n_bad++; $display("FAIL window_out got %h exp %h", obs_all, exp_all); end
    drv(1, 0, 32'h1, 2, 0, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    n_vec++;
    if (obs_all !== exp_all) begin n_bad++; $display("FAIL window_retire got %h exp %h", obs_all, exp_all); end
    drv(1, 8, 32'hAAAA5555, 1, 0, 1, 0, 0);
    tick();
    n_vec++;
    if (obs_all[73] !== 1'b1 || obs_all !== exp_all) begin n_bad++; $display("FAIL window_in got %h exp %h", obs_all, exp_all); end
  endtask

  task automatic test_wrap();
    int ids [4] = '{510, 511, 0, 1};
    drv(0, 0, 0, 0, 0, 1, 1, 510);
    tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drv(1, ids[c], $urandom, 4'(c), c[0], 1, 0, 0);
      else drv(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL wrap c%0d got %h exp %h", c, obs_all, exp_all); end
      if (c >= 1 && c <= 4) begin
        n_vec++;
        if (!(reg_we || acc_we) || retired_id !== 9'(ids[c-1])) begin n_bad++; $display("FAIL wrap_seq c%0d got id%0d exp %0d", c, retired_id, ids[c-1]); end
      end
    end
    n_vec++;
    if (next_id !== 9'd2) begin n_bad++; $display("FAIL wrap_next_id got %0d exp 2", next_id); end
  endtask

  task automatic test_stall();
    drv(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    for (int c = 0; c < 8; c++) begin
      if (c < 2) drv(1, 1 - c, $urandom, 4'(7 + c), 0, 1, 0, 0);
      else drv(0, 0, 0, 0, 0, !(c >= 2 && c <= 4), 0, 0);
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL stall c%0d got %h exp %h", c, obs_all, exp_all); end
      n_vec++;
      if ((c == 5 || c == 6) ? (!reg_we || retired_id !== 9'(c - 5)) : (reg_we || acc_we)) begin
        n_bad++;
        $display("FAIL stall_seq c%0d got we%b id%0d", c, reg_we, retired_id);
      end
    end
  endtask

  task automatic test_async_reset();
    drv(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(1, c < 3 ? c + 5 : 0, $urandom, 4'(c), 0, 1, 0, 0);
      tick();
    end
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    n_vec++;
    if (!reg_we || window_empty) begin n_bad++; $display("FAIL areset_pre got we%b empty%b exp we1 empty0", reg_we, window_empty); end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({reg_we, acc_we, retired_id, next_id, window_empty} !== {20'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL areset_now got we%b/%b id%0d next%0d empty%b", reg_we, acc_we, retired_id, next_id, window_empty);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drv(c == 3, 0, 32'hCAFEF00D, 4'd9, 1, 1, 0, 0);
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL areset_after c%0d got %h exp %h", c, obs_all, exp_all); end
      n_vec++;
      if ((c == 4) ? (!acc_we || acc_wdata !== 32'hCAFEF00D || retired_id !== 9'd0) : (reg_we || acc_we)) begin
        n_bad++;
        $display("FAIL areset_seq c%0d got we%b/%b data%h id%0d", c, reg_we, acc_we, acc_wdata, retired_id);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drv($urandom_range(3, 0) != 0, (m_next + $urandom_range(10, 0)) % 512, $urandom, 4'($urandom),
          $urandom_range(1, 0) == 1, $urandom_range(9, 0) != 0, $urandom_range(39, 0) == 0, $urandom_range(511, 0));
      tick();
      n_vec++;
      if (obs_all !== exp_all) begin n_bad++; $display("FAIL random c%0d got %h exp %h", c, obs_all, exp_all); end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_window();
    test_wrap();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
